fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter DataWidth, default 12, coefficient word width (SFix<1,DataWidth-1>).
REQ-002 SHALL have parameter NTaps, default 9, filter tap count; must be odd (even value SHALL fail elaboration).
REQ-003 SHALL derive localparam NCoeffs = (NTaps+1)/2, default 5; stream length NBits = NCoeffs*DataWidth, default 60.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstN, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port coeff_valid, input, 1, parallel coefficient word offered.
REQ-007 SHALL have port coeff_data, input, DataWidth, signed coefficient word.
REQ-008 SHALL have port coeff_ready, output, 1, loader accepts a word this cycle.
REQ-009 SHALL have port flush, input, 1, discard partially collected words.
REQ-010 SHALL have port fir_active, input, 1, filter mid-computation; serial stream must not start.
REQ-011 SHALL have port coeff_load_out, output, 1, drives filter serial-load enable.
REQ-012 SHALL have port coeff_out, output, 1, serial coefficient bit.
REQ-013 SHALL have port busy, output, 1, high in WAIT, SEND, DONE.
REQ-014 SHALL have port load_done, output, 1, single-cycle pulse after last serial bit.

Function
REQ-015 SHALL implement states COLLECT, WAIT, SEND, DONE.
REQ-016 COLLECT: coeff_ready=1; word accepted when coeff_valid && coeff_ready, written to buffer[word_cnt], word_cnt increments.
REQ-017 Accepted words SHALL be indexed 0..NCoeffs-1 in arrival order; index 0 is the coefficient applied to the newest/oldest outer sample pair, index NCoeffs-1 the centre tap.
REQ-018 flush in COLLECT SHALL clear word_cnt to 0 next cycle; flush with simultaneous handshake: flush wins, word discarded.
REQ-019 flush in WAIT, SEND, DONE SHALL be ignored; a started stream is never truncated.
REQ-020 On acceptance of word NCoeffs-1: next state SEND if fir_active=0 in that cycle, else WAIT; coeff_ready=0 from next cycle.
REQ-021 WAIT: coeff_ready=0, coeff_load_out=0; move to SEND on first cycle fir_active=0.
REQ-022 SEND: coeff_load_out=1 for exactly NBits consecutive cycles; fir_active ignored once SEND entered.
REQ-023 Bit order: buffer[NCoeffs-1] first, down to buffer[0] last; within each word MSB first, LSB last, so the first bit sent lands in the filter's last coefficient MSB.
REQ-024 coeff_out and coeff_load_out SHALL be registered outputs, changing only at clock edges; coeff_out=0 whenever coeff_load_out=0.
REQ-025 Counters: word index 0..NCoeffs-1, bit index 0..DataWidth-1; both wrap cleanly, no extra idle cycle between words.
REQ-026 DONE: one cycle, load_done=1, coeff_load_out=0; then COLLECT with word_cnt=0, coeff_ready=1.
REQ-027 Latency: last word accepted at cycle t with fir_active=0 -> coeff_load_out high cycles t+1..t+NBits, load_done at t+NBits+1, coeff_ready at t+NBits+2.
REQ-028 Buffer contents SHALL be retained after DONE until overwritten; no re-send without a fresh NCoeffs-word collection.

Reset
REQ-029 rstN=0 at a clock edge SHALL force COLLECT, word_cnt=0, bit counters 0, coeff_load_out=0, coeff_out=0, load_done=0, busy=0, coeff_ready=1 on the following cycle.
REQ-030 Reset mid-SEND SHALL abort the stream immediately; coeff_load_out low the cycle after reset sampled; no load_done pulse.
REQ-031 Buffer contents need not be cleared by reset.

Verification
REQ-032 Defaults, words 0x001,0x002,0x004,0x008,0x7FF, fir_active=0 -> 60-cycle load, bitstream 0x7FF,0x008,0x004,0x002,0x001 MSB-first; load_done at t+61.
REQ-033 Back-to-back with filter: loader output into filter, words {0x400,0,0,0,0} -> filter coeffs[0]=0x400, others 0.
REQ-034 fir_active=1 for 20 cycles after fifth word -> coeff_load_out stays 0 for 20 cycles, then 60 high cycles.
REQ-035 Three words accepted, flush=1 -> next five words 0x111..0x555 alone form the stream; first 3 discarded.
REQ-036 rstN=0 at bit 30 of SEND -> coeff_load_out=0 next cycle, load_done never pulses, coeff_ready=1.
REQ-037 coeff_valid held high through SEND -> no acceptance until COLLECT; sixth word taken as index 0 of next set.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Collects NCoeffs parallel coefficient words, then shifts them into the filter
// serially: highest word index first, MSB first, held off while the filter is busy.
module fir_coeff_loader #(
  parameter int DataWidth = 12,
  parameter int NTaps     = 9
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 coeff_valid,
  input  logic [DataWidth-1:0] coeff_data,
  output logic                 coeff_ready,
  input  logic                 flush,
  input  logic                 fir_active,
  output logic                 coeff_load_out,
  output logic                 coeff_out,
  output logic                 busy,
  output logic                 load_done
);

  localparam int NCoeffs = (NTaps + 1) / 2;
  localparam int NBits   = NCoeffs * DataWidth;
  localparam int WW      = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
  localparam int BW      = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam int IW      = (NBits > 1) ? $clog2(NBits) : 1;

  localparam logic [WW-1:0] LastWord = WW'(NCoeffs - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DataWidth - 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  generate
    if (NTaps % 2 == 0) begin : g_even_ntaps
      $error("fir_coeff_loader: NTaps must be odd");
    end
  endgenerate

  logic [1:0]           r_state;
  logic [WW-1:0]        r_word_cnt;
  logic [WW-1:0]        r_word_idx;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_load_out;
  logic                 r_coeff_out;
  logic                 r_load_done;
  logic [DataWidth-1:0] r_buf [NCoeffs];

  logic                 w_accept;
  logic                 w_last_bit;
  logic [WW-1:0]        w_next_word;
  logic [BW-1:0]        w_next_bit;
  logic [IW-1:0]        w_next_idx;
  logic [NBits-1:0]     w_flat;

  // Flat view of the buffer: bit b of word w sits at w*DataWidth + b.
  genvar gi;
  generate
    for (gi = 0; gi < NCoeffs; gi++) begin : g_flat
      assign w_flat[gi*DataWidth +: DataWidth] = r_buf[gi];
    end
  endgenerate

  assign coeff_ready = (r_state == S_COLLECT);
  assign busy        = (r_state != S_COLLECT);
  assign w_accept    = coeff_ready && coeff_valid && !flush;

  assign w_last_bit  = (r_word_idx == '0) && (r_bit_idx == '0);
  assign w_next_word = (r_bit_idx == '0) ? (r_word_idx - WW'(1)) : r_word_idx;
  assign w_next_bit  = (r_bit_idx == '0) ? LastBit : (r_bit_idx - BW'(1));
  assign w_next_idx  = IW'(w_next_word) * IW'(DataWidth) + IW'(w_next_bit);

  always_ff @(posedge clk) begin
    if (rstN && w_accept) begin
      r_buf[r_word_cnt] <= coeff_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state     <= S_COLLECT;
      r_word_cnt  <= '0;
      r_word_idx  <= '0;
      r_bit_idx   <= '0;
      r_load_out  <= 1'b0;
      r_coeff_out <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (flush) begin
            r_word_cnt <= '0;
          end else if (coeff_valid) begin
            if (r_word_cnt == LastWord) begin
              r_word_cnt <= '0;
              r_word_idx <= LastWord;
              r_bit_idx  <= LastBit;
              if (fir_active) begin
                r_state <= S_WAIT;
              end else begin
                // Final word is still on the bus, so its MSB leads the stream directly.
                r_state     <= S_SEND;
                r_load_out  <= 1'b1;
                r_coeff_out <= coeff_data[DataWidth-1];
              end
            end else begin
              r_word_cnt <= r_word_cnt + WW'(1);
            end
          end
        end
        S_WAIT: begin
          if (!fir_active) begin
            r_state     <= S_SEND;
            r_load_out  <= 1'b1;
            r_coeff_out <= w_flat[NBits-1];
          end
        end
        S_SEND: begin
          if (w_last_bit) begin
            r_state     <= S_DONE;
            r_load_out  <= 1'b0;
            r_coeff_out <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_word_idx  <= w_next_word;
            r_bit_idx   <= w_next_bit;
            r_coeff_out <= w_flat[w_next_idx];
          end
        end
        S_DONE: begin
          r_state <= S_COLLECT;
        end
        default: begin
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

  assign coeff_load_out = r_load_out;
  assign coeff_out      = r_coeff_out;
  assign load_done      = r_load_done;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: directed word sets push their expected
// serial streams; a negedge monitor pops and compares every loaded bit.
module tb_fir_coeff_loader;

  localparam int DW    = 12;
  localparam int NBITS = 60;

  logic          clk = 1'b0;
  logic          rstN;
  logic          coeff_valid;
  logic [DW-1:0] coeff_data;
  logic          coeff_ready;
  logic          flush;
  logic          fir_active;
  logic          coeff_load_out;
  logic          coeff_out;
  logic          busy;
  logic          load_done;

  int n_vec = 0;
  int n_bad = 0;

  logic exp_bits[$];
  logic exp_done[$];

  fir_coeff_loader #(.DataWidth(DW), .NTaps(9)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .coeff_valid    (coeff_valid),
    .coeff_data     (coeff_data),
    .coeff_ready    (coeff_ready),
    .flush          (flush),
    .fir_active     (fir_active),
    .coeff_load_out (coeff_load_out),
    .coeff_out      (coeff_out),
    .busy           (busy),
    .load_done      (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_stream(input logic [NBITS-1:0] s);
    for (int i = NBITS - 1; i >= 0; i--) exp_bits.push_back(s[i]);
    exp_done.push_back(1'b1);
  endtask

  // Offer one word from a negedge; returns at the negedge after the accepting edge.
  task automatic put(input logic [DW-1:0] d, input logic fa, input logic hold);
    int k;
    coeff_valid = 1'b1;
    coeff_data  = d;
    fir_active  = fa;
    k = 0;
    while (!coeff_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!coeff_ready) chk("put_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) coeff_valid = 1'b0;
  endtask

  // Called at the first negedge of a stream: length, done pulse, return to COLLECT.
  task automatic measure_load(input string nm);
    int n;
    n = 0;
    while (coeff_load_out && n < 200) begin
      chk({nm, "_busy"}, busy, 1);
      @(negedge clk);
      n++;
    end
    chk({nm, "_len"}, n, NBITS);
    chk({nm, "_done_pulse"}, load_done, 1);
    chk({nm, "_ready_in_done"}, coeff_ready, 0);
    @(negedge clk);
    chk({nm, "_done_clear"}, load_done, 0);
    chk({nm, "_ready_after"}, coeff_ready, 1);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin : monitor
    logic b;
    forever begin
      @(negedge clk);
      if (coeff_load_out) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_bit", 64'd1, 64'd0);
        end else begin
          b = exp_bits.pop_front();
          chk("serial_bit", coeff_out, b);
        end
      end else begin
        chk("idle_out_zero", coeff_out, 0);
      end
      if (load_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          void'(exp_done.pop_front());
          chk("bits_left_at_done", exp_bits.size(), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rstN        = 1'b0;
    coeff_valid = 1'b0;
    coeff_data  = '0;
    flush       = 1'b0;
    fir_active  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", coeff_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load_out", coeff_load_out, 0);
    chk("rst_coeff_out", coeff_out, 0);
    chk("rst_load_done", load_done, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Basic load, bitstream 7FF,008,004,002,001 MSB first.
    push_stream(60'h7FF_008_004_002_001);
    put(12'h001, 1'b0, 1'b0);
    put(12'h002, 1'b0, 1'b0);
    put(12'h004, 1'b0, 1'b0);
    chk("collect_ready_mid", coeff_ready, 1);
    put(12'h008, 1'b0, 1'b0);
    put(12'h7FF, 1'b0, 1'b0);
    chk("t1_start", coeff_load_out, 1);
    measure_load("t1");

    // Flush after three words; flush wins over a simultaneous handshake.
    put(12'hAAA, 1'b0, 1'b0);
    put(12'hBBB, 1'b0, 1'b0);
    put(12'hCCC, 1'b0, 1'b0);
    coeff_valid = 1'b1;
    coeff_data  = 12'hDDD;
    flush       = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    coeff_valid = 1'b0;
    push_stream(60'h555_444_333_222_111);
    put(12'h111, 1'b0, 1'b0);
    put(12'h222, 1'b0, 1'b0);
    put(12'h333, 1'b0, 1'b0);
    put(12'h444, 1'b0, 1'b0);
    chk("flush_no_early_start", coeff_load_out, 0);
    put(12'h555, 1'b0, 1'b0);
    chk("t2_start", coeff_load_out, 1);
    flush = 1'b1;   // must not truncate the running stream
    measure_load("t2");
    flush = 1'b0;

    // Filter busy for 20 cycles after the fifth word.
    push_stream(60'h000_000_000_000_400);
    put(12'h400, 1'b0, 1'b0);
    put(12'h000, 1'b0, 1'b0);
    put(12'h000, 1'b0, 1'b0);
    put(12'h000, 1'b0, 1'b0);
    put(12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("wait_load_low", coeff_load_out, 0);
      chk("wait_ready_low", coeff_ready, 0);
      chk("wait_busy", busy, 1);
      @(negedge clk);
    end
    fir_active = 1'b0;
    @(negedge clk);
    chk("t3_start", coeff_load_out, 1);
    fir_active = 1'b1;   // ignored once streaming
    measure_load("t3");
    fir_active = 1'b0;

    // Valid held through SEND: the held word becomes index 0 of the next set.
    push_stream(60'h456_123_0EF_0CD_0AB);
    put(12'h0AB, 1'b0, 1'b0);
    put(12'h0CD, 1'b0, 1'b0);
    put(12'h0EF, 1'b0, 1'b0);
    put(12'h123, 1'b0, 1'b0);
    put(12'h456, 1'b0, 1'b1);
    coeff_data = 12'h789;
    chk("t4_start", coeff_load_out, 1);
    measure_load("t4");
    push_stream(60'h801_F00_0F0_00F_789);
    @(negedge clk);
    coeff_valid = 1'b0;
    put(12'h00F, 1'b0, 1'b0);
    put(12'h0F0, 1'b0, 1'b0);
    put(12'hF00, 1'b0, 1'b0);
    put(12'h801, 1'b0, 1'b0);
    chk("t5_start", coeff_load_out, 1);
    measure_load("t5");

    // Reset at bit 30 of a stream aborts it without load_done.
    push_stream(60'h0F0_C3C_3C3_A5A_5A5);
    put(12'h5A5, 1'b0, 1'b0);
    put(12'hA5A, 1'b0, 1'b0);
    put(12'h3C3, 1'b0, 1'b0);
    put(12'hC3C, 1'b0, 1'b0);
    put(12'h0F0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("t6_mid_stream", coeff_load_out, 1);
    rstN = 1'b0;
    @(negedge clk);
    chk("abort_load_out", coeff_load_out, 0);
    chk("abort_load_done", load_done, 0);
    chk("abort_ready", coeff_ready, 1);
    chk("abort_busy", busy, 0);
    exp_bits.delete();
    exp_done.delete();
    rstN = 1'b1;
    repeat (70) @(negedge clk);
    chk("post_abort_ready", coeff_ready, 1);

    chk("final_bits_empty", exp_bits.size(), 0);
    chk("final_done_empty", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
